// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: jump conditions, sequencer
// states and the jump-resolution helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    JMP = 2'd0,
    JZ  = 2'd1,
    JNZ = 2'd2,
    JL  = 2'd3
  } jump_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  // JL is signed less-than: sign differs from overflow after a compare.
  function automatic logic jump_taken(input jump_t cond, input logic z,
                                      input logic s, input logic o);
    case (cond)
      JMP:     jump_taken = 1'b1;
      JZ:      jump_taken = z;
      JNZ:     jump_taken = ~z;
      JL:      jump_taken = s ^ o;
      default: jump_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO. The top entry is read combinationally; reset clears only
// the occupancy count, entry contents are don't-care until written.
module ret_stack #(
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [A_WIDTH-1:0]         data_in,
  output logic [A_WIDTH-1:0]         top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [A_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]      wr_idx;
  logic [IW-1:0]      rd_idx;

  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  assign wr_idx = IW'(depth);
  assign rd_idx = IW'(depth - DW'(1));
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst)
      depth <= '0;
    else if (push && !full)
      depth <= depth + DW'(1);
    else if (pop && !empty)
      depth <= depth - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_idx] <= data_in;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address register, jump resolution,
// CALL/RET return stack, single level interrupt, HALT and fetch stall.
//   state | meaning
//   RUN   | fetching and executing, addr advances or redirects
//   HALT  | addr frozen, waiting for an enabled interrupt
//   FAULT | stack over/underflow, frozen until reset
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                 A_WIDTH = 8,
  parameter int                 DEPTH   = 4,
  parameter logic [A_WIDTH-1:0] IRQ_VEC = A_WIDTH'('hF0)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_ready,
  input  logic                       is_jump,
  input  jump_t                      jump_cond,
  input  logic                       flag_z,
  input  logic                       flag_s,
  input  logic                       flag_o,
  input  logic [A_WIDTH-1:0]         jump_addr,
  input  logic                       is_call,
  input  logic                       is_ret,
  input  logic                       is_reti,
  input  logic                       is_halt,
  input  logic                       irq_req,
  output logic [A_WIDTH-1:0]         addr,
  output logic [A_WIDTH-1:0]         incremented,
  output logic                       irq_ack,
  output logic                       halted,
  output logic                       fault,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  pc_state_t          state, state_nxt;
  logic [A_WIDTH-1:0] addr_nxt;
  logic               irq_en, irq_en_nxt, ack_nxt;
  logic               push, pop, full, empty;
  logic [A_WIDTH-1:0] top;

  assign incremented = addr + A_WIDTH'(1);
  assign halted      = (state != RUN);
  assign fault       = (state == FAULT);

  ret_stack #(.A_WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .data_in(incremented),
    .top    (top),
    .depth  (depth),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      addr    <= '0;
      irq_en  <= 1'b1;
      irq_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      irq_en  <= irq_en_nxt;
      irq_ack <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    irq_en_nxt = irq_en;
    ack_nxt    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (mem_ready) begin
      case (state)
        RUN: begin
          if (is_halt) begin
            state_nxt = HALT;
          end else if (is_ret || is_reti) begin
            if (!empty) begin
              pop      = 1'b1;
              addr_nxt = top;
              if (is_reti) irq_en_nxt = 1'b1;
            end else begin
              state_nxt = FAULT;
            end
          end else if (is_call) begin
            if (!full) begin
              push     = 1'b1;
              addr_nxt = jump_addr;
            end else begin
              state_nxt = FAULT;
            end
          end else if (is_jump) begin
            addr_nxt = jump_taken(jump_cond, flag_z, flag_s, flag_o) ? jump_addr : incremented;
          end else if (irq_req && irq_en && !full) begin
            push       = 1'b1;
            addr_nxt   = IRQ_VEC;
            irq_en_nxt = 1'b0;
            ack_nxt    = 1'b1;
          end else begin
            addr_nxt = incremented;
          end
        end
        HALT: begin
          // Wake resumes at the instruction after HALT once the ISR returns.
          if (irq_req && irq_en && !full) begin
            push       = 1'b1;
            addr_nxt   = IRQ_VEC;
            irq_en_nxt = 1'b0;
            ack_nxt    = 1'b1;
            state_nxt  = RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed plan with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_pc_seq;
  import pc_seq_pkg::*;

  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst, mem_ready, is_jump, flag_z, flag_s, flag_o;
  logic        is_call, is_ret, is_reti, is_halt, irq_req;
  jump_t       jump_cond;
  logic [7:0]  jump_addr;
  logic [7:0]  addr, incremented;
  logic        irq_ack, halted, fault;
  logic [2:0]  depth;

  pc_seq #(.A_WIDTH(8), .DEPTH(DEP), .IRQ_VEC(8'hF0)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .is_jump(is_jump),
    .jump_cond(jump_cond), .flag_z(flag_z), .flag_s(flag_s), .flag_o(flag_o),
    .jump_addr(jump_addr), .is_call(is_call), .is_ret(is_ret), .is_reti(is_reti),
    .is_halt(is_halt), .irq_req(irq_req), .addr(addr), .incremented(incremented),
    .irq_ack(irq_ack), .halted(halted), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model: 0 = running, 1 = halted, 2 = faulted.
  int         m_addr, m_st, nxt;
  bit         m_irq_en, m_ack, tk;
  logic [7:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_addr = 0; m_st = 0; m_irq_en = 1; m_ack = 0;
      m_stack.delete();
    end else begin
      m_ack = 0;
      nxt = (m_addr + 1) % 256;
      if (mem_ready && m_st != 2) begin
        if (m_st == 1) begin
          if (irq_req && m_irq_en && m_stack.size() < DEP) begin
            m_stack.push_back(8'(nxt));
            m_addr = 'hF0; m_irq_en = 0; m_ack = 1; m_st = 0;
          end
        end else if (is_halt) begin
          m_st = 1;
        end else if (is_ret || is_reti) begin
          if (m_stack.size() == 0) m_st = 2;
          else begin
            m_addr = m_stack.pop_back();
            if (is_reti) m_irq_en = 1;
          end
        end else if (is_call) begin
          if (m_stack.size() == DEP) m_st = 2;
          else begin
            m_stack.push_back(8'(nxt));
            m_addr = jump_addr;
          end
        end else if (is_jump) begin
          case (jump_cond)
            JZ:      tk = flag_z;
            JNZ:     tk = !flag_z;
            JL:      tk = (flag_s != flag_o);
            default: tk = 1;
          endcase
          m_addr = tk ? int'(jump_addr) : nxt;
        end else if (irq_req && m_irq_en && m_stack.size() < DEP) begin
          m_stack.push_back(8'(nxt));
          m_addr = 'hF0; m_irq_en = 0; m_ack = 1;
        end else begin
          m_addr = nxt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("addr", addr, m_addr);
      chk("incremented", incremented, (m_addr + 1) % 256);
      chk("irq_ack", irq_ack, m_ack);
      chk("halted", halted, m_st != 0);
      chk("fault", fault, m_st == 2);
      chk("depth", depth, m_stack.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    is_jump = 0; is_call = 0; is_ret = 0; is_reti = 0; is_halt = 0;
  endtask

  // kind: 0 idle, 1 jump, 2 call, 3 ret, 4 reti, 5 halt
  task automatic do_op(input int kind, input logic [7:0] a, input jump_t c);
    clr();
    jump_addr = a;
    jump_cond = c;
    case (kind)
      1: is_jump = 1;
      2: is_call = 1;
      3: is_ret  = 1;
      4: is_reti = 1;
      5: is_halt = 1;
      default: ;
    endcase
    tick();
    clr();
  endtask

  initial begin
    rst = 1; mem_ready = 1; irq_req = 0; flag_z = 0; flag_s = 0; flag_o = 0;
    jump_cond = JMP; jump_addr = 0; clr();
    tick(); tick();
    rst = 0; started = 1;
    chk("rst_addr", addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ack", irq_ack, 0);
    for (int i = 1; i <= 3; i++) begin
      do_op(0, 0, JMP);
      chk("idle_addr", addr, i);
    end
    mem_ready = 0; tick(); tick();
    chk("stall_hold", addr, 3);
    mem_ready = 1;

    do_op(1, 8'h05, JMP); chk("jmp", addr, 8'h05);
    flag_z = 0; do_op(1, 8'h20, JZ); chk("jz_not_taken", addr, 8'h06);
    flag_s = 0; flag_o = 1; do_op(1, 8'h20, JL); chk("jl_taken", addr, 8'h20);
    flag_z = 1; do_op(1, 8'h44, JNZ); chk("jnz_not_taken", addr, 8'h21);
    do_op(1, 8'hFF, JMP); do_op(0, 0, JMP); chk("wrap", addr, 8'h00);

    do_op(1, 8'h10, JMP);
    do_op(2, 8'h40, JMP); chk("call1_addr", addr, 8'h40); chk("call1_depth", depth, 1);
    do_op(1, 8'h41, JMP);
    do_op(2, 8'h50, JMP); chk("call2_addr", addr, 8'h50); chk("call2_depth", depth, 2);
    do_op(3, 0, JMP);     chk("ret1_addr", addr, 8'h42);  chk("ret1_depth", depth, 1);
    do_op(3, 0, JMP);     chk("ret2_addr", addr, 8'h11);  chk("ret2_depth", depth, 0);

    do_op(1, 8'h07, JMP);
    irq_req = 1;
    do_op(0, 0, JMP); chk("irq_addr", addr, 8'hF0); chk("irq_ack", irq_ack, 1);
    do_op(0, 0, JMP); chk("irq_masked", addr, 8'hF1); chk("irq_ack_once", irq_ack, 0);
    do_op(4, 0, JMP); chk("reti_addr", addr, 8'h08); chk("reti_depth", depth, 0);
    do_op(0, 0, JMP); chk("irq_again", addr, 8'hF0); chk("irq_ack2", irq_ack, 1);
    irq_req = 0;
    do_op(4, 0, JMP); chk("reti2_addr", addr, 8'h09);

    do_op(1, 8'h30, JMP);
    do_op(5, 0, JMP); chk("halt_flag", halted, 1); chk("halt_addr", addr, 8'h30);
    for (int i = 0; i < 10; i++) begin
      do_op(0, 0, JMP);
      chk("halt_hold", addr, 8'h30);
    end
    irq_req = 1; mem_ready = 0; tick();
    chk("halt_stall_addr", addr, 8'h30); chk("halt_stall_ack", irq_ack, 0);
    mem_ready = 1;
    do_op(0, 0, JMP); chk("wake_addr", addr, 8'hF0); chk("wake_halted", halted, 0);
    irq_req = 0;
    do_op(4, 0, JMP); chk("wake_ret", addr, 8'h31);

    for (int i = 0; i < 4; i++) do_op(2, 8'h60, JMP);
    chk("full_depth", depth, 4);
    do_op(2, 8'h70, JMP); chk("ovf_fault", fault, 1); chk("ovf_addr", addr, 8'h60);
    do_op(3, 0, JMP); chk("fault_hold", addr, 8'h60);
    rst = 1; tick(); rst = 0;
    chk("rst_clear_addr", addr, 0); chk("rst_clear_fault", fault, 0);
    do_op(3, 0, JMP); chk("udf_fault", fault, 1); chk("udf_addr", addr, 0);
    rst = 1; tick(); rst = 0;

    for (int n = 0; n < 4000; n++) begin
      int k;
      rst       = ($urandom_range(99) == 0);
      mem_ready = ($urandom_range(3) != 0);
      flag_z    = $urandom_range(1);
      flag_s    = $urandom_range(1);
      flag_o    = $urandom_range(1);
      jump_cond = jump_t'($urandom_range(3));
      jump_addr = 8'($urandom);
      if ($urandom_range(7) == 0) irq_req = ~irq_req;
      k = $urandom_range(11);
      clr();
      case (k)
        1, 2: is_jump = 1;
        3:    is_call = 1;
        4:    is_ret  = 1;
        5:    is_reti = 1;
        6:    if ($urandom_range(3) == 0) is_halt = 1;
        default: ;
      endcase
      tick();
    end
    rst = 0; clr();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Program-counter sequencer for the single-cycle core: owns the instruction address register, resolves conditional jumps from ALU flags, and adds a hardware return-address stack (CALL/RET), one level-sensitive interrupt with entry/return, HALT, and a fetch-ready stall. It sits between the decoder/ALU flags and instruction memory, and is the only writer of the fetch address.

## Interface
- A_WIDTH, 8, address width.
- DEPTH, 4, return-stack entries (≥1).
- IRQ_VEC, 'hF0 truncated to A_WIDTH, interrupt entry address.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ready  in  1  instruction at addr valid this cycle; 0 = stall.
- is_jump  in  1  jump instruction.
- jump_cond  in  jump_t  JMP / JZ / JNZ / JL.
- flag_z, flag_s, flag_o  in  1 each  ALU zero / sign / overflow.
- jump_addr  in  A_WIDTH  jump/call target.
- is_call, is_ret, is_reti, is_halt  in  1 each  decoded control ops (at most one of is_jump/is_call/is_ret/is_reti/is_halt high).
- irq_req  in  1  level interrupt request.
- addr  out  A_WIDTH  registered fetch address.
- incremented  out  A_WIDTH  addr+1 mod 2^A_WIDTH (combinational).
- irq_ack  out  1  registered one-cycle pulse, high in the first cycle addr==IRQ_VEC after entry.
- halted  out  1  state != RUN.
- fault  out  1  state == FAULT.
- depth  out  $clog2(DEPTH+1)  current stack occupancy.

## Operation
- States: RUN, HALT, FAULT. Internal irq_en flag.
- Reset: addr=0, RUN, depth=0, irq_en=1, irq_ack=0, halted=0, fault=0.
- mem_ready=0: nothing changes (addr, state, stack, irq_en); decode inputs and irq_req ignored; irq_ack=0.
- RUN, mem_ready=1, priority:
  - is_halt → addr held, go HALT.
  - is_ret/is_reti, depth>0 → addr<=top, pop; is_reti also sets irq_en=1.
  - is_ret/is_reti, depth==0 → addr held, go FAULT.
  - is_call, depth<DEPTH → push incremented, addr<=jump_addr.
  - is_call, depth==DEPTH → addr held, no push, go FAULT.
  - is_jump → JMP: taken; JZ: taken iff flag_z; JNZ: taken iff !flag_z; JL: taken iff flag_s^flag_o. Taken → jump_addr, else incremented.
  - no control op, irq_req & irq_en & depth<DEPTH → push incremented, addr<=IRQ_VEC, irq_en=0, irq_ack next cycle.
  - otherwise addr<=incremented.
- Interrupts taken only on non-control instructions; deferred (not lost while level held) when stack full or irq_en=0.
- HALT: addr held; on mem_ready & irq_req & irq_en & depth<DEPTH → push incremented (instruction after HALT), addr<=IRQ_VEC, irq_en=0, back to RUN. Otherwise stays until reset.
- FAULT: everything held, irq ignored, exit only by reset.
- Wrap: addr all-ones increments to 0; pushed value wraps likewise.

## Timing
- addr, depth, state, irq_en, irq_ack are registers updated on the same edge; decision is combinational from inputs of that cycle.
- Redirect latency 1 cycle: decision in cycle n, new addr visible in n+1.
- irq_ack high exactly one cycle (n+1 after entry decision), never during stall.
- Stack top read combinationally; push and pop never in same cycle.
- rst wins over all inputs, including mid-stall and FAULT.

## Structure
- Shared enums package: existing jump_t (JMP, JZ, JNZ, JL); add pc_state_t {RUN, HALT, FAULT}.
- Sub-module ret_stack: parameterised LIFO (A_WIDTH, DEPTH) with push, pop, data_in, top, depth, full, empty; synchronous reset clears depth only.
- pc_seq holds state machine, irq_en, addr register, next-address mux.

## Test plan
- Reset then 3 idle cycles with mem_ready=1 → addr 0,1,2,3; mem_ready=0 for 2 cycles → addr holds 3.
- JZ to 0x20 with flag_z=0 at addr 5 → addr 6; JL with flag_s=0, flag_o=1 → addr 0x20; addr 0xFF idle → 0x00.
- CALL 0x40 at 0x10, CALL 0x50 at 0x41, RET, RET → addr 0x40, 0x50, 0x42, 0x11; depth 1,2,1,0.
- irq_req=1 at addr 7 (no control op) → addr 0xF0, irq_ack pulse, irq_en=0; second irq ignored; RETI → addr 8, irq taken again next non-control cycle if still high.
- HALT at 0x30 → halted=1, addr 0x30 held 10 cycles; irq_req → addr 0xF0; RETI → 0x31.
- DEPTH=4: 5 nested CALLs → FAULT on 5th, addr held, fault=1; RET with depth 0 after reset → FAULT; rst → addr 0, fault=0.
